rv151_wb_spi_loader: RTL and testbench

//  Wishbone-slave SPI host that lets the management SoC sequence the hdp_rv151 serial config/debug port.

---
 rtl/rv151_loader_pkg.sv | 27 ++
 rtl/rv151_spi_shifter.sv | 106 ++++++++++
 rtl/rv151_wb_spi_loader.sv | 139 +++++++++++++
 tb/tb_rv151_wb_spi_loader.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv151_loader_pkg.sv
// Shared definitions for the rv151 Wishbone SPI loader: register map, bit fields, FSM states.
package rv151_loader_pkg;

    localparam logic [7:0] OffCtrl   = 8'h00;
    localparam logic [7:0] OffStatus = 8'h04;
    localparam logic [7:0] OffTxData = 8'h08;
    localparam logic [7:0] OffRxData = 8'h0C;
    localparam logic [7:0] OffClkDiv = 8'h10;

    localparam int unsigned CtrlStart  = 0;
    localparam int unsigned CtrlCsHold = 1;
    localparam int unsigned CtrlBcf    = 2;
    localparam int unsigned CtrlIrqEn  = 3;

    localparam int unsigned StatBusy = 0;
    localparam int unsigned StatDone = 1;
    localparam int unsigned StatOvr  = 2;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StSetup   = 3'd1,
        StShiftLo = 3'd2,
        StShiftHi = 3'd3,
        StHold    = 3'd4
    } loader_state_e;

endpackage

// File: rtl/rv151_spi_shifter.sv
// Mode-0 SPI frame engine: clock divider, bit counter, shift register, SCS/SCK/SDI generation.
module rv151_spi_shifter
    import rv151_loader_pkg::*;
#(
    parameter int unsigned FrameBits = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 cs_hold_i,
    input  logic [FrameBits-1:0] tx_i,
    input  logic [7:0]           div_i,
    input  logic                 sdo_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [FrameBits-1:0] rx_o,
    output logic                 scs_o,
    output logic                 sck_o,
    output logic                 sdi_o
);

    localparam logic [5:0] LastBit = 6'(FrameBits);

    loader_state_e        state_q;
    logic [7:0]           cnt_q;
    logic [5:0]           bit_q;
    logic [FrameBits-1:0] shreg_q;
    logic [FrameBits-1:0] rx_q;
    logic                 busy_q, done_q, scs_q, sck_q, sdi_q;
    logic                 tick;

    assign tick = (cnt_q == div_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            rx_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            scs_q   <= 1'b1;
            sck_q   <= 1'b0;
            sdi_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != StIdle) begin
                cnt_q <= tick ? 8'd0 : cnt_q + 8'd1;
            end
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        shreg_q <= tx_i;
                        sdi_q   <= tx_i[FrameBits-1];
                        scs_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= StSetup;
                    end else begin
                        scs_q <= ~cs_hold_i;
                    end
                end
                StSetup, StShiftLo: begin
                    if (tick) begin
                        // The trailing low half-period ends the frame without another rise.
                        if (state_q == StShiftLo && bit_q == LastBit) begin
                            state_q <= StHold;
                        end else begin
                            sck_q   <= 1'b1;
                            shreg_q <= {shreg_q[FrameBits-2:0], sdo_i};
                            bit_q   <= bit_q + 6'd1;
                            state_q <= StShiftHi;
                        end
                    end
                end
                StShiftHi: begin
                    if (tick) begin
                        sck_q   <= 1'b0;
                        sdi_q   <= shreg_q[FrameBits-1];
                        state_q <= StShiftLo;
                    end
                end
                StHold: begin
                    if (tick) begin
                        rx_q    <= shreg_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        scs_q   <= ~cs_hold_i;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign rx_o   = rx_q;
    assign scs_o  = scs_q;
    assign sck_o  = sck_q;
    assign sdi_o  = sdi_q;

endmodule

// File: rtl/rv151_wb_spi_loader.sv
// Wishbone slave register block driving the rv151 serial config port through rv151_spi_shifter.
// Optional frame-done interrupt enabled by defining RV151_LOADER_IRQ_EN.
module rv151_wb_spi_loader
    import rv151_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned FRAME_BITS = 32,
    parameter logic [7:0]  DIV_RST    = 8'd3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        spi_scs_o,
    output logic        spi_sck_o,
    output logic        spi_sdi_o,
    input  logic        spi_sdo_i,
`ifdef RV151_LOADER_IRQ_EN
    output logic        irq_o,
`endif
    output logic        bcf_o
);

    logic                  ack_q;
    logic [31:0]           dat_q;
    logic                  cs_hold_q, bcf_q, done_q, ovr_q;
    logic [31:0]           tx_q;
    logic [7:0]            div_q;
    logic                  irq_en;
    logic                  hit, access, wr;
    logic                  wr_ctrl, wr_stat, wr_tx, wr_div;
    logic                  start_req, start, ovr_set;
    logic                  busy, done_pulse;
    logic [FRAME_BITS-1:0] rx;
    logic [7:0]            offset;
    logic [31:0]           rdata;
    logic                  unused_bits;

    assign hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign access    = hit & ~ack_q;
    assign wr        = access & wbs_we_i;
    assign offset    = {wbs_adr_i[7:2], 2'b00};
    assign wr_ctrl   = wr & (offset == OffCtrl);
    assign wr_stat   = wr & (offset == OffStatus);
    assign wr_tx     = wr & (offset == OffTxData) & (|wbs_sel_i);
    assign wr_div    = wr & (offset == OffClkDiv) & wbs_sel_i[0];
    assign start_req = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[CtrlStart];
    assign start     = start_req & ~busy;
    assign ovr_set   = busy & (start_req | wr_tx | wr_div);
    assign unused_bits = ^{wbs_adr_i[1:0], BASE_ADDR[7:0]};

`ifdef RV151_LOADER_IRQ_EN
    logic irq_en_q, irq_q;
    assign irq_en = irq_en_q;
    assign irq_o  = irq_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_ctrl & wbs_sel_i[0]) irq_en_q <= wbs_dat_i[CtrlIrqEn];
            irq_q <= done_q & irq_en_q;
        end
    end
`else
    assign irq_en = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (offset)
            OffCtrl:   rdata = {28'd0, irq_en, bcf_q, cs_hold_q, 1'b0};
            OffStatus: rdata = {29'd0, ovr_q, done_q, busy};
            OffTxData: rdata = tx_q;
            OffRxData: rdata = 32'(rx);
            OffClkDiv: rdata = {24'd0, div_q};
            default:   rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            cs_hold_q <= 1'b0;
            bcf_q     <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            tx_q      <= '0;
            div_q     <= DIV_RST;
        end else begin
            ack_q <= access;
            dat_q <= (access & ~wbs_we_i) ? rdata : 32'd0;
            if (wr_ctrl & wbs_sel_i[0]) begin
                cs_hold_q <= wbs_dat_i[CtrlCsHold];
                bcf_q     <= wbs_dat_i[CtrlBcf];
            end
            if (wr_tx & ~busy) begin
                for (int b = 0; b < 4; b++) begin
                    if (wbs_sel_i[b]) tx_q[8*b +: 8] <= wbs_dat_i[8*b +: 8];
                end
            end
            if (wr_div & ~busy) div_q <= wbs_dat_i[7:0];
            // A completing frame beats a simultaneous W1C.
            done_q <= done_pulse | (done_q & ~(wr_stat & wbs_sel_i[0] & wbs_dat_i[StatDone]));
            ovr_q  <= ovr_set | (ovr_q & ~(wr_stat & wbs_sel_i[0] & wbs_dat_i[StatOvr]));
        end
    end

    rv151_spi_shifter #(
        .FrameBits (FRAME_BITS)
    ) u_shifter (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .start_i   (start),
        .cs_hold_i (cs_hold_q),
        .tx_i      (tx_q[FRAME_BITS-1:0]),
        .div_i     (div_q),
        .sdo_i     (spi_sdo_i),
        .busy_o    (busy),
        .done_o    (done_pulse),
        .rx_o      (rx),
        .scs_o     (spi_scs_o),
        .sck_o     (spi_sck_o),
        .sdi_o     (spi_sdi_o)
    );

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign bcf_o     = bcf_q;

endmodule

// File: tb/tb_rv151_wb_spi_loader.sv
// Self-checking bench for rv151_wb_spi_loader; define RV151_LOADER_IRQ_EN to exercise irq_o.
module tb_rv151_wb_spi_loader;

    localparam logic [31:0] Base = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] dat_i = '0, adr = '0;
    logic        ack;
    logic [31:0] dat_o;
    logic        scs, sck, sdi, bcf;
    logic        sdo_bit;
`ifdef RV151_LOADER_IRQ_EN
    logic        irq;
`endif

    int          errors = 0;
    int          checks = 0;
    int          rises = 0;
    int          scs_lo = 0;
    int          scs_hi = 0;
    logic [31:0] sdi_cap = '0;
    logic        sdo_loop = 1'b0;
    logic [31:0] sdo_word = '0;

    always #5 clk = ~clk;

    rv151_wb_spi_loader dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_dat_i (dat_i),
        .wbs_adr_i (adr),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .spi_scs_o (scs),
        .spi_sck_o (sck),
        .spi_sdi_o (sdi),
        .spi_sdo_i (sdo_bit),
`ifdef RV151_LOADER_IRQ_EN
        .irq_o     (irq),
`endif
        .bcf_o     (bcf)
    );

    // Reference slave: presents sdo_word MSB-first, one bit per SCK rise, or echoes SDI.
    always_comb begin
        sdo_bit = 1'b0;
        if (sdo_loop) sdo_bit = sdi;
        else if (rises < 32) sdo_bit = sdo_word[5'(31 - rises)];
    end

    always @(posedge sck) begin
        rises   = rises + 1;
        sdi_cap = {sdi_cap[30:0], sdi};
    end

    always @(negedge clk) begin
        if (scs === 1'b0) scs_lo = scs_lo + 1;
        else scs_hi = scs_hi + 1;
    end

    task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd);
        bit ok;
        ok = 1'b0;
        rd = '0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) begin
                ok = 1'b1;
                rd = dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wb_ack_timeout addr=%h got no ack, required ack within 8 cycles", a);
        end
    endtask

    task automatic wb_write(input logic [7:0] off, input logic [31:0] d);
        logic [31:0] rd;
        wb_cycle(Base + 32'(off), 1'b1, d, 4'hF, rd);
    endtask

    task automatic wb_read(input logic [7:0] off, output logic [31:0] d);
        wb_cycle(Base + 32'(off), 1'b0, '0, 4'hF, d);
    endtask

    task automatic wait_idle();
        logic [31:0] st;
        for (int i = 0; i < 20000; i++) begin
            wb_read(8'h04, st);
            if (st[0] === 1'b0) return;
        end
        checks++;
        errors++;
        $display("FAIL busy_timeout frame still busy, required idle within 20000 polls");
    endtask

    task automatic clear_mon();
        rises = 0; scs_lo = 0; scs_hi = 0; sdi_cap = '0;
    endtask

    // One frame with the reference slave; checks length, edge count, sent and captured words.
    task automatic run_frame(input string name, input logic [7:0] div, input logic [31:0] tx,
                             input logic loop, input logic [31:0] word);
        logic [31:0] rd, exp_rx;
        int          exp_len;
        sdo_loop = loop;
        sdo_word = word;
        exp_rx   = loop ? tx : word;
        exp_len  = 66 * (int'(div) + 1);
        wb_write(8'h10, {24'd0, div});
        wb_write(8'h08, tx);
        wb_write(8'h04, 32'h6);
        clear_mon();
        wb_write(8'h00, 32'h1);
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (scs_lo !== exp_len) begin
            errors++;
            $display("FAIL %s_scs_len got %0d required %0d", name, scs_lo, exp_len);
        end
        checks++;
        if (rises !== 32) begin
            errors++;
            $display("FAIL %s_sck_rises got %0d required 32", name, rises);
        end
        checks++;
        if (sdi_cap !== tx) begin
            errors++;
            $display("FAIL %s_sdi_stream got %h required %h", name, sdi_cap, tx);
        end
        wb_read(8'h0C, rd);
        checks++;
        if (rd !== exp_rx) begin
            errors++;
            $display("FAIL %s_rxdata got %h required %h", name, rd, exp_rx);
        end
        wb_read(8'h04, rd);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("FAIL %s_status got %h required 00000002", name, rd);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] exp [5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h3};
        checks++;
        if ({scs, sck, sdi, bcf, ack} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_pins got %b required 10000", {scs, sck, sdi, bcf, ack});
        end
        for (int i = 0; i < 5; i++) begin
            wb_read(8'(4 * i), rd);
            checks++;
            if (rd !== exp[i]) begin
                errors++;
                $display("FAIL reset_reg_%0d got %h required %h", i, rd, exp[i]);
            end
        end
    endtask

    task automatic test_regs();
        logic [31:0] rd;
        wb_write(8'h00, 32'h4);
        #1;
        checks++;
        if (bcf !== 1'b1) begin
            errors++;
            $display("FAIL bcf_drive got %b required 1", bcf);
        end
        wb_read(8'h00, rd);
        checks++;
        if (rd !== 32'h4) begin
            errors++;
            $display("FAIL ctrl_read got %h required 00000004", rd);
        end
        wb_cycle(Base + 32'h10, 1'b1, 32'h55, 4'h0, rd);
        wb_read(8'h10, rd);
        checks++;
        if (rd !== 32'h3) begin
            errors++;
            $display("FAIL sel_masked_clkdiv got %h required 00000003", rd);
        end
        wb_write(8'h08, 32'h1122_3344);
        wb_cycle(Base + 32'h08, 1'b1, 32'hAABB_CCDD, 4'b0101, rd);
        wb_read(8'h08, rd);
        checks++;
        if (rd !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL sel_bytes_txdata got %h required 11bb33dd", rd);
        end
        wb_read(8'h20, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_read got %h required 00000000", rd);
        end
        wb_write(8'h00, 32'h0);
    endtask

    task automatic test_loopback();
        run_frame("loop", 8'd0, 32'hA5A5_0F0F, 1'b1, 32'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            run_frame("rand", 8'($urandom_range(0, 3)), $urandom, 1'b0, $urandom);
        end
    endtask

    task automatic test_div_max();
        run_frame("divmax", 8'd255, $urandom, 1'b0, $urandom);
    endtask

    task automatic test_overrun();
        logic [31:0] rd, tx, word;
        tx   = $urandom;
        word = $urandom;
        sdo_loop = 1'b0;
        sdo_word = word;
        wb_write(8'h10, 32'h3);
        wb_write(8'h08, tx);
        wb_write(8'h04, 32'h6);
        clear_mon();
        wb_write(8'h00, 32'h1);
        wb_write(8'h00, 32'h1);
        wb_write(8'h08, ~tx);
        wb_read(8'h04, rd);
        checks++;
        if (rd !== 32'h5) begin
            errors++;
            $display("FAIL ovr_busy_status got %h required 00000005", rd);
        end
        wait_idle();
        repeat (2) @(posedge clk);
        checks++;
        if (sdi_cap !== tx || rises !== 32) begin
            errors++;
            $display("FAIL ovr_frame_intact got %h/%0d required %h/32", sdi_cap, rises, tx);
        end
        wb_read(8'h08, rd);
        checks++;
        if (rd !== tx) begin
            errors++;
            $display("FAIL ovr_tx_ignored got %h required %h", rd, tx);
        end
        wb_read(8'h04, rd);
        checks++;
        if (rd !== 32'h6) begin
            errors++;
            $display("FAIL ovr_done_status got %h required 00000006", rd);
        end
        wb_write(8'h04, 32'h4);
        wb_read(8'h04, rd);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("FAIL ovr_w1c got %h required 00000002", rd);
        end
        wb_write(8'h04, 32'h2);
        wb_read(8'h04, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL done_w1c got %h required 00000000", rd);
        end
    endtask

    task automatic test_cs_hold();
        logic [31:0] rd, w2;
        w2 = $urandom;
        sdo_loop = 1'b0;
        sdo_word = $urandom;
        wb_write(8'h10, 32'h1);
        wb_write(8'h00, 32'h2);
        repeat (2) @(posedge clk);
        clear_mon();
        wb_write(8'h00, 32'h3);
        wait_idle();
        repeat (3) @(posedge clk);
        rises    = 0;
        sdo_word = w2;
        wb_write(8'h00, 32'h3);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (scs_hi !== 0) begin
            errors++;
            $display("FAIL cshold_scs_low got %0d high cycles required 0", scs_hi);
        end
        wb_read(8'h0C, rd);
        checks++;
        if (rd !== w2 || rises !== 32) begin
            errors++;
            $display("FAIL cshold_frame2 got %h/%0d required %h/32", rd, rises, w2);
        end
        wb_write(8'h00, 32'h0);
        @(posedge clk); #1;
        checks++;
        if (scs !== 1'b1) begin
            errors++;
            $display("FAIL cshold_release got %b required 1", scs);
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rd;
        int          r0;
        bit          hit;
        sdo_loop = 1'b0;
        sdo_word = $urandom;
        wb_write(8'h10, 32'h1);
        wb_write(8'h08, $urandom);
        clear_mon();
        wb_write(8'h00, 32'h1);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rises >= 10) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL midframe_bit10_timeout got %0d rises required 10", rises);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (scs !== 1'b1 || sck !== 1'b0) begin
            errors++;
            $display("FAIL midframe_pins got scs=%b sck=%b required scs=1 sck=0", scs, sck);
        end
        r0 = rises;
        repeat (40) @(posedge clk);
        checks++;
        if (rises !== r0) begin
            errors++;
            $display("FAIL midframe_no_edges got %0d rises required %0d", rises, r0);
        end
        wb_read(8'h04, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL midframe_status got %h required 00000000", rd);
        end
        wb_read(8'h0C, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL midframe_rxdata got %h required 00000000", rd);
        end
    endtask

    task automatic test_miss();
        int acks;
        acks = 0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = Base + 32'h100; sel = 4'hF;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack === 1'b1) acks++;
        end
        cyc = 1'b0; stb = 1'b0;
        checks++;
        if (acks !== 0) begin
            errors++;
            $display("FAIL miss_no_ack got %0d acks required 0", acks);
        end
    endtask

    task automatic test_back_to_back();
        int acks;
        acks = 0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = Base + 32'h10; sel = 4'hF;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack === 1'b1) acks++;
        end
        cyc = 1'b0; stb = 1'b0;
        checks++;
        if (acks !== 3) begin
            errors++;
            $display("FAIL held_strobe_acks got %0d acks required 3", acks);
        end
    endtask

`ifdef RV151_LOADER_IRQ_EN
    task automatic test_irq();
        wb_write(8'h10, 32'h0);
        wb_write(8'h00, 32'h9);
        wait_idle();
        repeat (2) @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set got %b required 1", irq);
        end
        wb_write(8'h04, 32'h2);
        repeat (2) @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear got %b required 0", irq);
        end
        wb_write(8'h00, 32'h0);
    endtask
`endif

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_regs();
        test_loopback();
        test_random();
        test_overrun();
        test_cs_hold();
        test_div_max();
        test_reset_midframe();
        test_miss();
        test_back_to_back();
`ifdef RV151_LOADER_IRQ_EN
        test_irq();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
